// File: rtl/jtopl_pg_enc_pkg.sv
// Shared types and limits for the phase-increment encoder.
package jtopl_pg_enc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_DONE = 2'd2
    } pg_enc_st_t;

    localparam logic [9:0]  FNUM_MAX  = 10'd1023;
    localparam logic [2:0]  BLK_MAX   = 3'd7;
    // Largest phinc reachable: (1023 << 7) >> 1
    localparam logic [16:0] PHINC_MAX = 17'd65472;

endpackage

// File: rtl/jtopl_pg_enc_fin.sv
// Finalise step: optional rounding, renormalise on fnum overflow, saturate.
module jtopl_pg_enc_fin
    import jtopl_pg_enc_pkg::*;
#(
    parameter int ROUND = 0
) (
    input  logic [9:0] xlo,
    input  logic       hi,
    input  logic [2:0] b,
    input  logic       rbit,
    output logic [2:0] block,
    output logic [9:0] fnum,
    output logic       sat
);

    logic [10:0] f;

    assign f = {1'b0, xlo} + 11'd1;

    // Pick result: clamp if still too wide, else round (if enabled) and renormalise
    always_comb begin
        block = b;
        fnum  = xlo;
        sat   = 1'b0;
        if (hi) begin
            block = BLK_MAX;
            fnum  = FNUM_MAX;
            sat   = 1'b1;
        end else if ((ROUND != 0) && rbit) begin
            if (f[10]) begin
                // Rounding carried out of 10 bits: 1024 << b == 512 << (b+1)
                if (b < BLK_MAX) begin
                    block = b + 3'd1;
                    fnum  = 10'd512;
                end else begin
                    block = BLK_MAX;
                    fnum  = FNUM_MAX;
                    sat   = 1'b1;
                end
            end else begin
                fnum = f[9:0];
            end
        end
    end

endmodule

// File: rtl/jtopl_pg_enc.sv
// Phase-increment to (block, fnum) encoder: one right shift per clock until
// the doubled target fits in 10 bits or the octave limit is reached.
module jtopl_pg_enc
    import jtopl_pg_enc_pkg::*;
#(
    parameter int ROUND = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [16:0] phinc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  block,
    output logic [9:0]  fnum,
    output logic        sat
);

    pg_enc_st_t  st, st_nxt;
    logic [17:0] x;
    logic [2:0]  b;
    logic        rbit;
    logic        hi;
    logic        norm_end;
    logic [2:0]  fin_block;
    logic [9:0]  fin_fnum;
    logic        fin_sat;

    assign hi       = |x[17:10];
    assign norm_end = !hi || (b == BLK_MAX);

    assign in_ready  = (st == ST_IDLE);
    assign out_valid = (st == ST_DONE);

    jtopl_pg_enc_fin #(.ROUND(ROUND)) u_fin (
        .xlo   (x[9:0]),
        .hi    (hi),
        .b     (b),
        .rbit  (rbit),
        .block (fin_block),
        .fnum  (fin_fnum),
        .sat   (fin_sat)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) st <= ST_IDLE;
        else        st <= st_nxt;
    end

    // Next-state: accept in IDLE, shift until normalised, hold until consumed
    always_comb begin
        st_nxt = st;
        case (st)
            ST_IDLE: if (in_valid)  st_nxt = ST_NORM;
            ST_NORM: if (norm_end)  st_nxt = ST_DONE;
            ST_DONE: if (out_ready) st_nxt = ST_IDLE;
            default:                st_nxt = ST_IDLE;
        endcase
    end

    // Normaliser datapath: load doubled target, shift right one step per cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x    <= '0;
            b    <= '0;
            rbit <= 1'b0;
        end else begin
            case (st)
                ST_IDLE: if (in_valid) begin
                    x    <= {phinc, 1'b0};
                    b    <= '0;
                    rbit <= 1'b0;
                end
                ST_NORM: if (!norm_end) begin
                    x    <= x >> 1;
                    b    <= b + 3'd1;
                    rbit <= x[0];
                end
                default: ;
            endcase
        end
    end

    // Result registers: captured once at the end of NORM, held afterwards
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            block <= '0;
            fnum  <= '0;
            sat   <= 1'b0;
        end else if ((st == ST_NORM) && norm_end) begin
            block <= fin_block;
            fnum  <= fin_fnum;
            sat   <= fin_sat;
        end
    end

endmodule

// File: tb/tb_jtopl_pg_enc.sv
// Bench for jtopl_pg_enc: truncating and rounding instances driven in lockstep,
// checked against an arithmetic model of the encoding rules.
module tb_jtopl_pg_enc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [16:0] phinc;
    logic        ir0, ov0, sat0, ir1, ov1, sat1;
    logic [2:0]  blk0, blk1;
    logic [9:0]  fn0, fn1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    jtopl_pg_enc #(.ROUND(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0),
        .phinc(phinc), .out_valid(ov0), .out_ready(out_ready),
        .block(blk0), .fnum(fn0), .sat(sat0)
    );

    jtopl_pg_enc #(.ROUND(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
        .phinc(phinc), .out_valid(ov1), .out_ready(out_ready),
        .block(blk1), .fnum(fn1), .sat(sat1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Smallest octave whose window holds 2*p; optional half-up rounding on the dropped bit
    function automatic void ref_enc(input int p, input bit rnd,
                                    output int blk, output int fn, output int st, output int lat);
        int v, b;
        v = p * 2;
        b = 0;
        while (b < 7 && (v >> b) >= 1024) b++;
        lat = b + 1;
        if ((v >> b) >= 1024) begin
            blk = 7; fn = 1023; st = 1;
            return;
        end
        blk = b; fn = v >> b; st = 0;
        if (rnd && b > 0 && (((v >> (b - 1)) & 1) == 1)) begin
            fn = fn + 1;
            if (fn == 1024) begin
                if (b < 7) begin blk = b + 1; fn = 512; end
                else begin blk = 7; fn = 1023; st = 1; end
            end
        end
    endfunction

    task automatic encode(input int p, input int stall, input bit noise);
        int eb0, ef0, es0, el0, eb1, ef1, es1, el1, cyc;
        ref_enc(p, 1'b0, eb0, ef0, es0, el0);
        ref_enc(p, 1'b1, eb1, ef1, es1, el1);
        @(negedge clk);
        phinc = p[16:0];
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("in_ready_busy", ir0, 0);
        cyc = 0;
        while (!ov0 && cyc < 12) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk($sformatf("latency p=%0d", p), cyc, el0);
        chk("ov_round_inst", ov1, 1);
        chk($sformatf("blk0 p=%0d", p), blk0, eb0);
        chk($sformatf("fn0 p=%0d", p), fn0, ef0);
        chk($sformatf("sat0 p=%0d", p), sat0, es0);
        chk($sformatf("blk1 p=%0d", p), blk1, eb1);
        chk($sformatf("fn1 p=%0d", p), fn1, ef1);
        chk($sformatf("sat1 p=%0d", p), sat1, es1);
        repeat (stall) begin
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                phinc = 17'($urandom);
            end
            @(posedge clk); #1;
            chk("stall_ov", ov0, 1);
            chk("stall_in_ready", ir0, 0);
            chk("stall_fn0", fn0, ef0);
            chk("stall_blk1", blk1, eb1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_ov", ov0, 0);
        chk("post_in_ready", ir0, 1);
        chk("post_hold_fn0", fn0, ef0);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        phinc = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", ir0, 1);
        chk("rst_out_valid", ov0, 0);
        chk("rst_block", blk0, 0);
        chk("rst_fnum", fn0, 0);
        chk("rst_sat", sat0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed corners
        encode(0, 0, 1'b0);
        encode(600, 1, 1'b0);
        encode(1000, 0, 1'b0);
        encode(1023, 0, 1'b0);
        encode(2047, 2, 1'b0);
        encode(65472, 0, 1'b0);
        encode(65473, 0, 1'b0);
        encode(70000, 0, 1'b0);
        encode(131071, 0, 1'b0);
        // Long consumer stall with in_valid noise
        encode(12345, 20, 1'b1);

        // Reset in the middle of a long normalisation
        @(negedge clk);
        phinc = 17'd65472;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_in_ready", ir0, 1);
        chk("midrst_out_valid", ov0, 0);
        chk("midrst_block", blk0, 0);
        chk("midrst_fnum", fn0, 0);
        chk("midrst_sat", sat0, 0);
        chk("midrst_ov1", ov1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        encode(3000, 0, 1'b0);

        // Random sweep with random idle gaps and stalls
        for (int i = 0; i < 200; i++) begin
            int p;
            case ($urandom_range(0, 2))
                0:       p = int'($urandom_range(0, 131071));
                1:       p = int'($urandom_range(0, 65535));
                default: p = int'($urandom_range(0, 4095));
            endcase
            repeat ($urandom_range(0, 2)) @(posedge clk);
            encode(p, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
